// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package seq_pkg;

    localparam int PC_W  = 32;
    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        CL_ALU_R   = 3'd0,
        CL_ALU_I   = 3'd1,
        CL_LOAD    = 3'd2,
        CL_STORE   = 3'd3,
        CL_BRANCH  = 3'd4,
        CL_ILLEGAL = 3'd5
    } instr_class_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Datapath handshake bundle between the sequencer (master) and the datapath (slave).
interface multicycle_sequencer_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        ir_we;
    logic        pc_we;
    logic        pc_sel;
    logic        rf_we;
    logic        dmem_re;
    logic        dmem_we;

    modport master (
        input  instr, mem_ready, branch_taken,
        output ir_we, pc_we, pc_sel, rf_we, dmem_re, dmem_we
    );

    modport slave (
        output instr, mem_ready, branch_taken,
        input  ir_we, pc_we, pc_sel, rf_we, dmem_re, dmem_we
    );
endinterface

// File: rtl/multicycle_sequencer_opcode_classifier.sv
// Combinational opcode -> instruction class map; unknown opcodes map to CL_ILLEGAL.
module opcode_classifier
    import seq_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t cls
);

    // Decode the major opcode field.
    always_comb begin
        cls = CL_ILLEGAL;
        case (opcode)
            OP_ALU_R:  cls = CL_ALU_R;
            OP_ALU_I:  cls = CL_ALU_I;
            OP_LOAD:   cls = CL_LOAD;
            OP_STORE:  cls = CL_STORE;
            OP_BRANCH: cls = CL_BRANCH;
            default:   cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with one instruction in flight.
// Optional performance counters are built when SEQ_PERF_COUNTERS_EN is defined;
// otherwise cycle_count and instret are tied to zero with the same port list.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// FETCH  | capture instr into the instruction register
// DECODE | classify opcode, latch class (illegal -> HALT)
// EXEC   | ALU op, or branch resolve + retire
// MEM    | load/store request held until mem_ready
// WB     | register write-back + retire
// HALT   | stopped by halt_req or illegal opcode, waiting for start
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W = seq_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    halt_req,
    multicycle_sequencer_if.master  dp,
    output logic                    retire,
    output logic                    busy,
    output logic                    illegal,
    output logic [2:0]              state,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [CNT_W-1:0]        instret
);

    state_t       state_q, state_d;
    instr_class_t class_q, class_d;
    logic         illegal_q, illegal_d;
    instr_class_t dec_class;

    logic ir_we, pc_we, pc_sel, rf_we, dmem_re, dmem_we;

    // Only the major opcode field steers the sequencer; the rest belongs to the datapath.
    logic unused_instr_hi;
    assign unused_instr_hi = ^dp.instr[31:7];

    opcode_classifier u_classifier (
        .opcode (dp.instr[6:0]),
        .cls    (dec_class)
    );

    // Moore strobe decode from state/class; pc_sel follows branch_taken in EXEC and
    // a store retires in the MEM cycle where mem_ready arrives.
    always_comb begin
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 1'b0;
        rf_we   = 1'b0;
        dmem_re = 1'b0;
        dmem_we = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH: ir_we = 1'b1;
            ST_EXEC: begin
                if (class_q == CL_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = dp.branch_taken;
                    retire = 1'b1;
                end
            end
            ST_MEM: begin
                if (class_q == CL_LOAD) begin
                    dmem_re = 1'b1;
                end else begin
                    dmem_we = 1'b1;
                    if (dp.mem_ready) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
            end
            ST_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state, class latch and sticky illegal flag.
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                class_d = dec_class;
                if (dec_class == CL_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (class_q == CL_LOAD || class_q == CL_STORE) state_d = ST_MEM;
                else if (class_q == CL_BRANCH) state_d = halt_req ? ST_HALT : ST_FETCH;
                else state_d = ST_WB;
            end
            ST_MEM: begin
                if (dp.mem_ready) begin
                    if (class_q == CL_LOAD) state_d = ST_WB;
                    else state_d = halt_req ? ST_HALT : ST_FETCH;
                end
            end
            ST_WB:     state_d = halt_req ? ST_HALT : ST_FETCH;
            ST_HALT: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    illegal_d = 1'b0;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers; reset drops any in-flight memory request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            class_q   <= CL_ALU_R;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign illegal    = illegal_q;
    assign state      = state_q;
    assign dp.ir_we   = ir_we;
    assign dp.pc_we   = pc_we;
    assign dp.pc_sel  = pc_sel;
    assign dp.rf_we   = rf_we;
    assign dp.dmem_re = dmem_re;
    assign dp.dmem_we = dmem_we;

`ifdef SEQ_PERF_COUNTERS_EN
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    // Free-running counters, wrap naturally at 2^CNT_W.
    always_comb begin
        cycle_count_d = cycle_count_q + CNT_W'(busy);
        instret_d     = instret_q + CNT_W'(retire);
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count_q <= '0;
            instret_q     <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instret_q     <= instret_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign instret     = instret_q;
`else
    assign cycle_count = '0;
    assign instret     = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer; inputs driven and outputs sampled around the falling edge.
module tb_multicycle_sequencer;

    localparam int CNT_W = 32;
    localparam logic [31:0] I_ADD  = 32'h00C58533;
    localparam logic [31:0] I_LD   = 32'h0085B503;
    localparam logic [31:0] I_SD   = 32'h00B53423;
    localparam logic [31:0] I_BEQ  = 32'h00B50463;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
`ifdef SEQ_PERF_COUNTERS_EN
    localparam logic [63:0] EXP_CYC = 64'd40;
    localparam logic [63:0] EXP_RET = 64'd10;
`else
    localparam logic [63:0] EXP_CYC = 64'd0;
    localparam logic [63:0] EXP_RET = 64'd0;
`endif

    logic clk = 1'b0;
    logic reset, start, halt_req;
    logic retire, busy, illegal;
    logic [2:0] state;
    logic [CNT_W-1:0] cycle_count, instret;

    int checks = 0;
    int failures = 0;

    multicycle_sequencer_if dp_if ();

    multicycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt_req    (halt_req),
        .dp          (dp_if.master),
        .retire      (retire),
        .busy        (busy),
        .illegal     (illegal),
        .state       (state),
        .cycle_count (cycle_count),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge while the DUT is in FETCH; returns at the falling edge after retire.
    task automatic run_instr(input logic [31:0] word, input int waits, input logic taken,
                             input logic hreq, output int cyc, output int re_cnt, output int we_cnt,
                             output logic [2:0] ret_st, output logic ret_rf, output logic ret_pc,
                             output logic ret_sel, output logic first_ir);
        int mem_k;
        logic done;
        cyc = 0; re_cnt = 0; we_cnt = 0; mem_k = 0; done = 1'b0;
        ret_st = 3'd7; ret_rf = 1'b0; ret_pc = 1'b0; ret_sel = 1'b0; first_ir = 1'b0;
        start = 1'b0;
        dp_if.instr = word;
        dp_if.branch_taken = taken;
        halt_req = hreq;
        while (!done && cyc < 20) begin
            cyc++;
            if (state == 3'd4) begin
                dp_if.mem_ready = (mem_k >= waits);
                mem_k++;
            end else begin
                dp_if.mem_ready = (waits == 0);
            end
            #1;
            if (cyc == 1) first_ir = dp_if.ir_we;
            if (dp_if.dmem_re) re_cnt++;
            if (dp_if.dmem_we) we_cnt++;
            chk("re_we_excl", 64'(dp_if.dmem_re & dp_if.dmem_we), 64'd0);
            if (state != 3'd5) chk("pc_rf_excl", 64'(dp_if.pc_we & dp_if.rf_we), 64'd0);
            if (retire) begin
                done = 1'b1;
                ret_st = state; ret_rf = dp_if.rf_we; ret_pc = dp_if.pc_we; ret_sel = dp_if.pc_sel;
            end
            @(negedge clk);
        end
        chk("retire_seen", 64'(done), 64'd1);
        halt_req = 1'b0;
    endtask

    int cyc, re_cnt, we_cnt;
    logic [2:0] ret_st;
    logic ret_rf, ret_pc, ret_sel, first_ir;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; halt_req = 1'b0;
        dp_if.instr = I_ADD; dp_if.mem_ready = 1'b0; dp_if.branch_taken = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_strobes", 64'({dp_if.ir_we, dp_if.pc_we, dp_if.rf_we, dp_if.dmem_re, dp_if.dmem_we, retire}), 64'd0);
        chk("rst_counters", 64'({cycle_count, instret}), 64'd0);

        // release and start in the same cycle: first edge sees IDLE with start
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("start_fetch", 64'(state), 64'd1);
        chk("fetch_busy", 64'(busy), 64'd1);

        run_instr(I_ADD, 0, 1'b0, 1'b0, cyc, re_cnt, we_cnt, ret_st, ret_rf, ret_pc, ret_sel, first_ir);
        chk("alu_ir_we", 64'(first_ir), 64'd1);
        chk("alu_cycles", 64'(cyc), 64'd4);
        chk("alu_ret_state", 64'(ret_st), 64'd5);
        chk("alu_rf_pc", 64'({ret_rf, ret_pc, ret_sel}), 64'b110);
        chk("alu_next", 64'(state), 64'd1);

        run_instr(I_LD, 3, 1'b0, 1'b0, cyc, re_cnt, we_cnt, ret_st, ret_rf, ret_pc, ret_sel, first_ir);
        chk("ld_cycles", 64'(cyc), 64'd8);
        chk("ld_re_cnt", 64'(re_cnt), 64'd4);
        chk("ld_we_cnt", 64'(we_cnt), 64'd0);
        chk("ld_rf_pc", 64'({ret_rf, ret_pc, ret_sel}), 64'b110);

        run_instr(I_BEQ, 0, 1'b1, 1'b0, cyc, re_cnt, we_cnt, ret_st, ret_rf, ret_pc, ret_sel, first_ir);
        chk("beq_t_cycles", 64'(cyc), 64'd3);
        chk("beq_t_state", 64'(ret_st), 64'd3);
        chk("beq_t_rf_pc_sel", 64'({ret_rf, ret_pc, ret_sel}), 64'b011);

        run_instr(I_BEQ, 0, 1'b0, 1'b0, cyc, re_cnt, we_cnt, ret_st, ret_rf, ret_pc, ret_sel, first_ir);
        chk("beq_nt_cycles", 64'(cyc), 64'd3);
        chk("beq_nt_rf_pc_sel", 64'({ret_rf, ret_pc, ret_sel}), 64'b010);

        // halt_req held from FETCH through a stalled store: must only act on the retire cycle
        run_instr(I_SD, 2, 1'b0, 1'b1, cyc, re_cnt, we_cnt, ret_st, ret_rf, ret_pc, ret_sel, first_ir);
        chk("sd_cycles", 64'(cyc), 64'd6);
        chk("sd_we_cnt", 64'(we_cnt), 64'd3);
        chk("sd_re_cnt", 64'(re_cnt), 64'd0);
        chk("sd_ret_state", 64'(ret_st), 64'd4);
        chk("sd_rf_pc_sel", 64'({ret_rf, ret_pc, ret_sel}), 64'b010);
        chk("sd_halted", 64'(state), 64'd6);
        chk("halt_busy", 64'(busy), 64'd0);

        start = 1'b1;
        @(negedge clk);
        chk("halt_restart", 64'(state), 64'd1);
        start = 1'b0;
        dp_if.instr = I_BAD;
        @(negedge clk);
        chk("bad_decode", 64'(state), 64'd2);
        @(negedge clk);
        chk("bad_state", 64'(state), 64'd6);
        chk("bad_illegal", 64'(illegal), 64'd1);
        chk("bad_strobes", 64'({dp_if.ir_we, dp_if.pc_we, dp_if.rf_we, dp_if.dmem_re, dp_if.dmem_we, retire, busy}), 64'd0);
        @(negedge clk);
        chk("bad_sticky", 64'({state, illegal}), 64'({3'd6, 1'b1}));
        start = 1'b1;
        @(negedge clk);
        chk("bad_clear_state", 64'(state), 64'd1);
        chk("bad_clear_illegal", 64'(illegal), 64'd0);
        start = 1'b0;

        // reset mid-MEM of a load
        dp_if.instr = I_LD; dp_if.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("midmem_state", 64'(state), 64'd4);
        chk("midmem_re", 64'(dp_if.dmem_re), 64'd1);
        reset = 1'b0;
        #1;
        chk("rstmem_state", 64'(state), 64'd0);
        chk("rstmem_outs", 64'({dp_if.ir_we, dp_if.pc_we, dp_if.pc_sel, dp_if.rf_we, dp_if.dmem_re, dp_if.dmem_we, retire, busy, illegal}), 64'd0);
        chk("rstmem_counters", 64'({cycle_count, instret}), 64'd0);
        dp_if.mem_ready = 1'b1;
        @(negedge clk);
        chk("rstmem_hold", 64'(state), 64'd0);

        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            run_instr(I_ADD, 0, 1'b0, (i == 9), cyc, re_cnt, we_cnt, ret_st, ret_rf, ret_pc, ret_sel, first_ir);
            chk("perf_alu_cycles", 64'(cyc), 64'd4);
        end
        chk("perf_halted", 64'(state), 64'd6);
        chk("perf_instret", 64'(instret), EXP_RET);
        chk("perf_cycle_count", 64'(cycle_count), EXP_CYC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
